// File: rtl/otbn_pq_pkg.sv
// otbn_pq_pkg: shared NTT mode enum and LogN-bit reversal helper for the OTBN PQ blocks
package otbn_pq_pkg;
  typedef enum logic {
    NttModeCt = 1'b0,
    NttModeGs = 1'b1
  } ntt_mode_e;
  localparam int MaxLogN = 12;
  function automatic logic [MaxLogN-1:0] bitrev(input logic [MaxLogN-1:0] v, input int w);
    logic [MaxLogN-1:0] r;
    r = '0;
    for (int i = 0; i < MaxLogN; i++) if (i < w) r[i] = v[w-1-i];
    return r;
  endfunction
endpackage

// File: rtl/otbn_pq_ntt_idx_gen.sv
// otbn_pq_ntt_idx_gen: butterfly index/twiddle sequencer for CT (forward) and GS (inverse) NTT
// Ports: clk_i, rst_ni (async active-low); start_i/mode_i launch, abort_i cancels;
// idx_valid_o/idx_ready_i handshake on (idx0_o, idx1_o, tw_idx_o, stage_o, last_o);
// busy_o high in Run/Done, done_o one-cycle completion pulse.
// Macro OTBN_PQ_NTT_IDX_BITREV_EN: when defined, tw_idx_o is the LogN-bit bit-reversal of k.
module otbn_pq_ntt_idx_gen
  import otbn_pq_pkg::*;
#(
  parameter int LogN = 8,
  localparam int StageW = $clog2(LogN)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic              abort_i,
  input  logic              idx_ready_i,
  output logic              idx_valid_o,
  output logic [LogN-1:0]   idx0_o,
  output logic [LogN-1:0]   idx1_o,
  output logic [LogN-1:0]   tw_idx_o,
  output logic [StageW-1:0] stage_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  localparam logic [LogN-1:0] One = LogN'(1);
  localparam logic [LogN-1:0] NHalf = {1'b1, {(LogN-1){1'b0}}};
  state_e state_q, state_d;
  ntt_mode_e mode_q;
  logic [StageW-1:0] s_q;
  logic [LogN-1:0] j_q, len_q, k_q, j_inc;
  logic run, hs, gs, grp_end, stg_end, last;
  assign run = state_q == StRun;
  assign hs = run & idx_ready_i;
  assign gs = mode_q == NttModeGs;
  assign j_inc = j_q + One;
  // groups are aligned to 2*len, so crossing into the len bit marks the end of a group
  assign grp_end = |(j_inc & len_q);
  // last j of a stage is N-1-len, which in LogN bits is simply ~len
  assign stg_end = j_q == ~len_q;
  assign last = run & (s_q == StageW'(LogN - 1)) & stg_end;
  always_comb begin
    state_d = state_q == StIdle ? (start_i ? StRun : StIdle) :
              state_q == StRun  ? (abort_i ? StIdle : (hs && last) ? StDone : StRun) :
              StIdle;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else state_q <= state_d;
  end
  // counters are held at zero everywhere outside Run, so outputs need no extra gating
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= NttModeCt;
      s_q <= '0;
      j_q <= '0;
      len_q <= '0;
      k_q <= '0;
    end else if (state_q == StIdle && start_i) begin
      mode_q <= ntt_mode_e'(mode_i);
      s_q <= '0;
      j_q <= '0;
      len_q <= mode_i ? One : NHalf;
      k_q <= mode_i ? '1 : One;
    end else if (run && (abort_i || (idx_ready_i && last))) begin
      mode_q <= NttModeCt;
      s_q <= '0;
      j_q <= '0;
      len_q <= '0;
      k_q <= '0;
    end else if (hs) begin
      j_q <= stg_end ? '0 : grp_end ? j_inc + len_q : j_inc;
      k_q <= grp_end ? (gs ? k_q - One : k_q + One) : k_q;
      if (stg_end) begin
        s_q <= s_q + StageW'(1);
        len_q <= gs ? len_q << 1 : len_q >> 1;
      end
    end
  end
  assign idx_valid_o = run;
  assign idx0_o = j_q;
  assign idx1_o = j_q + len_q;
`ifdef OTBN_PQ_NTT_IDX_BITREV_EN
  assign tw_idx_o = LogN'(bitrev(MaxLogN'(k_q), LogN));
`else
  assign tw_idx_o = k_q;
`endif
  assign stage_o = s_q;
  assign last_o = last;
  assign busy_o = state_q != StIdle;
  assign done_o = state_q == StDone;
endmodule

// File: tb/tb_otbn_pq_ntt_idx_gen.sv
// tb_otbn_pq_ntt_idx_gen: randomized scoreboard bench for otbn_pq_ntt_idx_gen (LogN=3)
module tb_otbn_pq_ntt_idx_gen;
  localparam int LogN = 3;
  localparam int N = 1 << LogN;
  localparam int SW = $clog2(LogN);
  typedef struct {
    int i0;
    int i1;
    int tw;
    int st;
    bit last;
  } tup_t;
  logic clk = 0, rst_n = 0, start = 0, mode = 0, abort = 0, ready = 0;
  logic valid, last, busy, done;
  logic [LogN-1:0] idx0, idx1, tw;
  logic [SW-1:0] stage;
  tup_t exp_q[$];
  int vectors = 0, errors = 0, hs_cnt = 0;
  otbn_pq_ntt_idx_gen #(.LogN(LogN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .abort_i(abort),
    .idx_ready_i(ready), .idx_valid_o(valid), .idx0_o(idx0), .idx1_o(idx1),
    .tw_idx_o(tw), .stage_o(stage), .last_o(last), .busy_o(busy), .done_o(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int tw_ref(input int k);
`ifdef OTBN_PQ_NTT_IDX_BITREV_EN
    int r = 0;
    for (int b = 0; b < LogN; b++) if ((k >> b) & 1) r |= 1 << (LogN - 1 - b);
    return r;
`else
    return k;
`endif
  endfunction
  task automatic build(input bit gs);
    int k = gs ? N - 1 : 1;
    for (int s = 0; s < LogN; s++) begin
      int len = gs ? (1 << s) : (N >> (s + 1));
      for (int g = 0; g < N; g += 2 * len) begin
        for (int j = g; j < g + len; j++)
          exp_q.push_back('{j, j + len, tw_ref(k), s, (s == LogN - 1) && (j == N - 1 - len)});
        k = gs ? k - 1 : k + 1;
      end
    end
  endtask
  initial begin
    bit held_v = 0, exp_done = 0;
    tup_t held, a, e;
    forever begin
      @(negedge clk);
      a = '{int'(idx0), int'(idx1), int'(tw), int'(stage), last};
      chk("done", done, exp_done);
      chk("busy", busy, valid | done);
      exp_done = 0;
      if (valid) begin
        if (held_v) chk("stable", {a.i0[7:0], a.i1[7:0], a.tw[7:0], a.st[6:0], a.last},
                        {held.i0[7:0], held.i1[7:0], held.tw[7:0], held.st[6:0], held.last});
        if (ready) begin
          hs_cnt++;
          held_v = 0;
          if (exp_q.size() == 0) chk("extra_tuple", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("idx0", a.i0, e.i0);
            chk("idx1", a.i1, e.i1);
            chk("tw_idx", a.tw, e.tw);
            chk("stage", a.st, e.st);
            chk("last", a.last, e.last);
            exp_done = e.last && !abort;
          end
        end else begin
          held_v = 1;
          held = a;
        end
      end else begin
        held_v = 0;
        chk("idle_zero", idx0 | idx1 | tw | stage | last, 0);
      end
    end
  end
  // act: 0 = complete run, 1 = abort on the 5th tuple, 2 = reset after 6 tuples
  task automatic run(input bit gs, input bit rnd, input int act);
    int base = hs_cnt, cyc = 0;
    bit fin = 0;
    build(gs);
    start = 1;
    mode = gs;
    @(posedge clk); #1;
    start = 0;
    chk("first_valid", valid, 1);
    while (!fin) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = 1'($urandom_range(0, 1));
      abort = 0;
      if (act == 1 && hs_cnt - base == 4 && valid) begin
        ready = 1;
        abort = 1;
        fin = 1;
      end
      if (act == 2 && hs_cnt - base == 6) begin
        fin = 1;
        #2 rst_n = 0;
        #1 chk("async_reset", {valid, idx0, idx1, tw, stage, last, busy, done}, 0);
      end
      @(posedge clk); #1;
      if (done) fin = 1;
      if (++cyc > 300) begin
        chk("timeout", cyc, 0);
        fin = 1;
      end
    end
    start = 0;
    abort = 0;
    ready = 0;
    if (act == 0) chk("all_consumed", exp_q.size(), 0);
    if (act == 1) chk("abort_idle", {valid, busy}, 0);
    if (act == 2) begin
      @(posedge clk); #3 rst_n = 1;
    end
    @(posedge clk); #1;
    exp_q.delete();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 chk("reset_state", {valid, idx0, idx1, tw, stage, last, busy, done}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    run(0, 0, 0);
    run(1, 0, 0);
    run(0, 1, 0);
    run(1, 1, 0);
    run(0, 1, 1);
    run(0, 0, 0);
    run(0, 1, 2);
    run(0, 1, 0);
    abort = 1;
    repeat (3) @(posedge clk);
    #1 chk("idle_abort", {valid, busy}, 0);
    abort = 0;
    run(1, 1, 1);
    for (int i = 0; i < 6; i++) run(1'($urandom_range(0, 1)), 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
